branch_resolve_unit: RTL and testbench

Parametrised successor to the single-cycle branch flush logic. It resolves conditional branches and jumps, checks each outcome against a per-PC 2-bit prediction from a branch history table (BHT), and issues flush plus redirect on mispredict or jump. It also serves the IF-stage prediction lookup. The unit sits between ID/EX (resolution) and IF (lookup, redirect mux).

---
 rtl/bru_pkg.sv | 32 +++
 rtl/branch_cmp.sv | 33 +++
 rtl/branch_resolve_unit.sv | 102 ++++++++++
 tb/tb_branch_resolve_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bru_pkg : shared constants and counter helper for branch resolution  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] BHT_RESET_VAL = CNT_WNT;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != CNT_ST) nxt = cnt + 2'd1;
    else if (!taken && cnt != CNT_SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cmp : combinational branch condition evaluator                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_cmp
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            legal
);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3)
      F3_BEQ:  taken = (op1 == op2);
      F3_BNE:  taken = (op1 != op2);
      F3_BLT:  taken = ($signed(op1) <  $signed(op2));
      F3_BGE:  taken = ($signed(op1) >= $signed(op2));
      F3_BLTU: taken = (op1 <  op2);
      F3_BGEU: taken = (op1 >= op2);
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolve_unit : branch/jump resolution, flush/redirect and BHT |
// | Optional perf counters enabled by defining BRU_PERF_CNT_EN.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_if,
  output logic            pred_taken_if,
  input  logic            res_valid,
  input  logic            stall,
  input  logic            branch,
  input  logic            jump,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] pc_res,
  input  logic [XLEN-1:0] target_res,
  input  logic            pred_taken_res,
  output logic            flush_IF,
  output logic            flush_ID,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  logic [1:0]      bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] res_idx;
  logic            active;
  logic            cmp_taken;
  logic            cmp_legal;
  logic            br_valid;
  logic            mispredict;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic            unused_pc_bits;

  assign if_idx  = pc_if[IDX_W+1:2];
  assign res_idx = pc_res[IDX_W+1:2];
  assign unused_pc_bits = ^{pc_if[XLEN-1:IDX_W+2], pc_if[1:0],
                            pc_res[XLEN-1:IDX_W+2], pc_res[1:0]};

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .op1    (op1),
    .op2    (op2),
    .funct3 (funct3),
    .taken  (cmp_taken),
    .legal  (cmp_legal)
  );

  // Reset gating here keeps flushes quiet while rst is high.
  assign active     = res_valid & ~stall & ~rst;
  assign br_valid   = active & branch & ~jump & cmp_legal;
  assign mispredict = br_valid & (cmp_taken != pred_taken_res);
  assign redirect   = (active & jump) | mispredict;
  assign pc_plus4   = pc_res + {{(XLEN-3){1'b0}}, 3'd4};

  assign flush_IF       = redirect;
  assign flush_ID       = redirect;
  assign redirect_valid = redirect;
  assign redirect_pc    = (jump || cmp_taken) ? target_res : pc_plus4;

  // Lookup reads the array combinationally, so a same-cycle write is not yet visible.
  assign pred_taken_if = ~rst & bht[if_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_RESET_VAL;
    end else if (br_valid) begin
      bht[res_idx] <= cnt_next(bht[res_idx], cmp_taken);
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else begin
      if (br_valid && perf_branches != 32'hFFFF_FFFF)
        perf_branches <= perf_branches + 32'd1;
      if (mispredict && perf_mispredicts != 32'hFFFF_FFFF)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_resolve_unit : directed + random bench with reference model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_if;
  logic            pred_taken_if;
  logic            res_valid, stall, branch, jump;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1, op2, pc_res, target_res;
  logic            pred_taken_res;
  logic            flush_IF, flush_ID, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     perf_branches, perf_mispredicts;
`endif

  int tests = 0;
  int fails = 0;

  int          model_cnt [DEPTH];
  longint      model_pb = 0;
  longint      model_pm = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_if          (pc_if),
    .pred_taken_if  (pred_taken_if),
    .res_valid      (res_valid),
    .stall          (stall),
    .branch         (branch),
    .jump           (jump),
    .funct3         (funct3),
    .op1            (op1),
    .op2            (op2),
    .pc_res         (pc_res),
    .target_res     (target_res),
    .pred_taken_res (pred_taken_res),
    .flush_IF       (flush_IF),
    .flush_ID       (flush_ID),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  // Spec-level condition evaluation: returns -1 for an illegal funct3.
  function automatic int cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (f3)
      3'd0: return (a == b) ? 1 : 0;
      3'd1: return (a != b) ? 1 : 0;
      3'd4: return (sa <  sb) ? 1 : 0;
      3'd5: return (sa >= sb) ? 1 : 0;
      3'd6: return (longint'(a) <  longint'(b)) ? 1 : 0;
      3'd7: return (longint'(a) >= longint'(b)) ? 1 : 0;
      default: return -1;
    endcase
  endfunction

  task automatic step(input logic r, input logic rv, input logic st, input logic br,
                      input logic jp, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pcr, input logic [31:0] tgt,
                      input logic prd, input logic [31:0] pci);
    int  c;
    bit  act, upd, mis, exp_flush;
    logic [31:0] exp_pc;
    @(negedge clk);
    rst = r; res_valid = rv; stall = st; branch = br; jump = jp; funct3 = f3;
    op1 = a; op2 = b; pc_res = pcr; target_res = tgt; pred_taken_res = prd; pc_if = pci;
    #1;
    c   = cond(f3, a, b);
    act = !r && rv && !st;
    upd = act && !jp && br && (c >= 0);
    mis = upd && ((c == 1) != prd);
    exp_flush = (act && jp) || mis;
    exp_pc = jp ? tgt : ((c == 1) ? tgt : pcr + 32'd4);
    chk("flush_IF", {31'd0, flush_IF}, {31'd0, exp_flush});
    chk("flush_ID", {31'd0, flush_ID}, {31'd0, exp_flush});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_flush});
    if (exp_flush) chk("redirect_pc", redirect_pc, exp_pc);
    chk("pred_taken_if", {31'd0, pred_taken_if},
        {31'd0, (!r && model_cnt[bidx(pci)] >= 2)});
    @(posedge clk);
    if (r) begin
      foreach (model_cnt[i]) model_cnt[i] = 1;
      model_pb = 0;
      model_pm = 0;
    end else if (upd) begin
      if (c == 1) model_cnt[bidx(pcr)] = (model_cnt[bidx(pcr)] < 3) ? model_cnt[bidx(pcr)] + 1 : 3;
      else        model_cnt[bidx(pcr)] = (model_cnt[bidx(pcr)] > 0) ? model_cnt[bidx(pcr)] - 1 : 0;
      if (model_pb < 64'hFFFF_FFFF) model_pb++;
      if (mis && model_pm < 64'hFFFF_FFFF) model_pm++;
    end
`ifdef BRU_PERF_CNT_EN
    #1;
    chk("perf_branches", perf_branches, model_pb[31:0]);
    chk("perf_mispredicts", perf_mispredicts, model_pm[31:0]);
`endif
  endtask

  function automatic logic mpred(input logic [31:0] pc);
    return model_cnt[bidx(pc)] >= 2;
  endfunction

  initial begin
    logic [31:0] ra, rb, rp, rpi;
    logic [2:0]  rf;
    foreach (model_cnt[i]) model_cnt[i] = 1;
    rst = 1'b1; res_valid = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    funct3 = 3'd0; op1 = '0; op2 = '0; pc_res = '0; target_res = '0;
    pred_taken_res = 1'b0; pc_if = '0;

    // Reset: flushes stay low even with a valid jump presented.
    step(1, 1, 0, 0, 1, 3'd0, 0, 0, 32'h100, 32'h80, 0, 32'h100);
    step(1, 1, 0, 1, 1, 3'd0, 0, 0, 32'h100, 32'h80, 0, 32'h100);
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h100);

    // beq taken, predicted not-taken, then lookup sees weak-taken.
    step(0, 1, 0, 1, 0, 3'd0, 5, 5, 32'h100, 32'h140, 0, 32'h100);
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h100);

    // bge signed not-taken with wrong prediction; redirect to pc+4.
    step(0, 1, 0, 1, 0, 3'd5, 32'hFFFF_FFFF, 1, 32'h200, 32'h240, 1, 32'h200);
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h200);

    // bltu training at 0x300: four taken, two not-taken, lookup on same pc.
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 1, 0, 3'd6, 1, 2, 32'h300, 32'h380, mpred(32'h300), 32'h300);
    for (int i = 0; i < 2; i++)
      step(0, 1, 0, 1, 0, 3'd6, 3, 2, 32'h300, 32'h380, mpred(32'h300), 32'h300);
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h300);

    // Jump with branch set: jump wins, BHT untouched; stalled copy does nothing.
    step(0, 1, 0, 1, 1, 3'd0, 7, 7, 32'h100, 32'h80, 0, 32'h100);
    step(0, 1, 1, 1, 1, 3'd0, 7, 7, 32'h100, 32'h80, 0, 32'h100);
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h100);

    // Illegal funct3 never flushes or trains.
    step(0, 1, 0, 1, 0, 3'd2, 1, 1, 32'h100, 32'h180, 1, 32'h100);
    step(0, 1, 0, 1, 0, 3'd3, 1, 2, 32'h100, 32'h180, 0, 32'h100);

    // pc+4 wraps at the top of the address space.
    step(0, 1, 0, 1, 0, 3'd1, 9, 9, 32'hFFFF_FFFC, 32'h10, 1, 32'hFFFF_FFFC);

    for (int n = 0; n < 400; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rf = 3'($urandom_range(0, 7));
      rp = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rpi = ($urandom_range(0, 2) == 0) ? rp : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1) | ($urandom_range(0, 1) & 0)) | ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), rf, ra, rb, rp, $urandom,
           ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : mpred(rp), rpi);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
